aes_kat_sequencer: RTL and testbench

AES_KAT_SEQUENCER -- requirements
Module: aes_kat_sequencer

---
 rtl/aes_kat_sequencer.sv | 167 ++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kat_sequencer.sv
// AES known-answer-test sequencer: latches one test vector, runs an encrypt
// then a decrypt of the captured ciphertext on an external AES core, and
// reports pass/fail with saturating tallies. Each core wait is bounded.
module aes_kat_sequencer #(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [127:0]       pt_in,
  input  logic [127:0]       exp_ct_in,
  input  logic [Nk*32-1:0]   key_in,
  output logic               core_start,
  output logic               core_mode,
  output logic [127:0]       core_data,
  output logic [Nk*32-1:0]   core_key,
  input  logic               core_done,
  input  logic [127:0]       core_result,
  output logic               busy,
  output logic               done,
  output logic               enc_pass,
  output logic               dec_pass,
  output logic               timeout,
  output logic [CNT_W-1:0]   pass_count,
  output logic [CNT_W-1:0]   fail_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_params
    $error("aes_kat_sequencer: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  typedef enum logic [2:0] {
    IDLE, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, REPORT
  } state_t;

  state_t              state_q, state_d;
  logic [127:0]        pt_q, exp_ct_q, ct_cap_q;
  logic [Nk*32-1:0]    key_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                latch_en, enc_cap, dec_cap, to_hit, wait_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A WAIT state spans at most TIMEOUT cycles; a core_done in the last of
  // them is still accepted because the done branch is tested first.
  assign wait_last = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
  assign core_key  = key_q;

  // Next-state, core handshake and capture strobes.
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    core_mode  = 1'b0;
    core_data  = pt_q;
    busy       = 1'b1;
    latch_en   = 1'b0;
    enc_cap    = 1'b0;
    dec_cap    = 1'b0;
    to_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch_en = 1'b1;
          state_d  = ENC_REQ;
        end
      end
      ENC_REQ: begin
        core_start = 1'b1;
        state_d    = ENC_WAIT;
      end
      ENC_WAIT: begin
        if (core_done) begin
          enc_cap = 1'b1;
          state_d = DEC_REQ;
        end else if (wait_last) begin
          to_hit  = 1'b1;
          state_d = REPORT;
        end
      end
      DEC_REQ: begin
        core_start = 1'b1;
        core_mode  = 1'b1;
        core_data  = ct_cap_q;
        state_d    = DEC_WAIT;
      end
      DEC_WAIT: begin
        core_mode = 1'b1;
        core_data = ct_cap_q;
        if (core_done) begin
          dec_cap = 1'b1;
          state_d = REPORT;
        end else if (wait_last) begin
          to_hit  = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, wait counter, result flags, tallies and done.
  // done is registered off REPORT so it rises together with the updated
  // tallies, giving start-to-done = 4 + both core latencies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      done       <= 1'b0;
      enc_pass   <= 1'b0;
      dec_pass   <= 1'b0;
      timeout    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == REPORT);
      if (state_q == ENC_REQ || state_q == DEC_REQ)
        wait_cnt_q <= '0;
      else if (state_q == ENC_WAIT || state_q == DEC_WAIT)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      if (latch_en) begin
        enc_pass <= 1'b0;
        dec_pass <= 1'b0;
        timeout  <= 1'b0;
      end
      if (enc_cap) enc_pass <= (core_result == exp_ct_q);
      if (dec_cap) dec_pass <= (core_result == pt_q);
      if (to_hit) begin
        timeout  <= 1'b1;
        enc_pass <= 1'b0;
        dec_pass <= 1'b0;
      end
      if (state_q == REPORT) begin
        if (enc_pass && dec_pass && !timeout) pass_count <= sat_inc(pass_count);
        else                                  fail_count <= sat_inc(fail_count);
      end
    end
  end

  // Test vector and captured ciphertext; cleared by reset so every output
  // reads zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pt_q     <= '0;
      exp_ct_q <= '0;
      key_q    <= '0;
      ct_cap_q <= '0;
    end else begin
      if (latch_en) begin
        pt_q     <= pt_in;
        exp_ct_q <= exp_ct_in;
        key_q    <= key_in;
      end
      if (enc_cap) ct_cap_q <= core_result;
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: two instances (AES-128 with 2-bit tallies,
// AES-256 with 8-bit tallies) each served by a behavioural core model.
module tb_aes_kat_sequencer;

  localparam int T = 64;
  localparam logic [255:0] K128   = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KPT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KCT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KCT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus
  logic         sel, drv_start, a_spur, b_spur, corrupt;
  logic [127:0] drv_pt, drv_exp;
  logic [255:0] drv_key;
  int           lat1, lat2;

  int n_checks = 0, n_errors = 0;
  int e_pc[2], e_fc[2];
  int cap[2] = '{3, 255};

  // Behavioural core: KAT table answers, otherwise an invertible toy cipher.
  function automatic logic [127:0] core_fn(input logic mode, input logic [127:0] d,
                                           input logic [255:0] k);
    logic [127:0] kf, y;
    if (k == K128 && !mode && d == KPT)    return KCT128;
    if (k == K128 &&  mode && d == KCT128) return KPT;
    if (k == K256 && !mode && d == KPT)    return KCT256;
    if (k == K256 &&  mode && d == KCT256) return KPT;
    kf = k[127:0] ^ k[255:128];
    if (!mode) return {d[119:0], d[127:120]} ^ kf;
    y = d ^ kf;
    return {y[7:0], y[127:8]};
  endfunction

  // ---------------- instance A: Nk=4, CNT_W=2
  logic a_start, a_cstart, a_cmode, a_cdone, a_busy, a_done, a_enc, a_dec, a_to;
  logic a_cdone_m = 1'b0;
  logic [127:0] a_cdata, a_ckey, a_cres = '0;
  logic [1:0] a_pc, a_fc;
  assign a_start = drv_start & ~sel;
  assign a_cdone = a_cdone_m | a_spur;

  aes_kat_sequencer #(.Nk(4), .Nr(10), .TIMEOUT(T), .CNT_W(2)) u_dut_a (
    .clk(clk), .reset(rst), .start(a_start), .pt_in(drv_pt), .exp_ct_in(drv_exp),
    .key_in(drv_key[127:0]), .core_start(a_cstart), .core_mode(a_cmode),
    .core_data(a_cdata), .core_key(a_ckey), .core_done(a_cdone), .core_result(a_cres),
    .busy(a_busy), .done(a_done), .enc_pass(a_enc), .dec_pass(a_dec), .timeout(a_to),
    .pass_count(a_pc), .fail_count(a_fc));

  int a_rem = 0, a_starts = 0, a_bad = 0;
  logic a_cm = 1'b0, a_cc = 1'b0, a_chk = 1'b0;
  logic [127:0] a_cd = '0, a_seen_enc = '0, a_seen_dec = '0;
  logic [255:0] a_ck = '0, a_seen_key = '0;
  logic [256:0] a_snap = '0;

  always @(negedge clk) begin
    a_cdone_m = 1'b0;
    if (a_rem > 0) begin
      a_rem = a_rem - 1;
      if (a_rem == 0) begin
        a_cdone_m = 1'b1;
        a_cres = core_fn(a_cm, a_cd, a_ck) ^ {127'b0, a_cm & a_cc};
      end
    end
    if (rst) a_chk = 1'b0;
    else if (a_chk) begin
      if ({a_cmode, a_cdata, a_ckey} !== a_snap) a_bad++;
      if (a_cdone_m | a_spur) a_chk = 1'b0;
    end
    if (a_cstart) begin
      a_starts++;
      if (a_cmode) a_seen_dec = a_cdata;
      else begin a_seen_enc = a_cdata; a_seen_key = {128'b0, a_ckey}; end
      a_cm = a_cmode; a_cd = a_cdata; a_ck = {128'b0, a_ckey}; a_cc = corrupt;
      a_rem = a_cmode ? lat2 : lat1;
      a_chk = (a_rem > 0 && a_rem <= T);
      a_snap = {a_cmode, a_cdata, a_ckey};
    end
  end

  // ---------------- instance B: Nk=8, CNT_W=8
  logic b_start, b_cstart, b_cmode, b_cdone, b_busy, b_done, b_enc, b_dec, b_to;
  logic b_cdone_m = 1'b0;
  logic [127:0] b_cdata, b_cres = '0;
  logic [255:0] b_ckey;
  logic [7:0] b_pc, b_fc;
  assign b_start = drv_start & sel;
  assign b_cdone = b_cdone_m | b_spur;

  aes_kat_sequencer #(.Nk(8), .Nr(14), .TIMEOUT(T), .CNT_W(8)) u_dut_b (
    .clk(clk), .reset(rst), .start(b_start), .pt_in(drv_pt), .exp_ct_in(drv_exp),
    .key_in(drv_key), .core_start(b_cstart), .core_mode(b_cmode),
    .core_data(b_cdata), .core_key(b_ckey), .core_done(b_cdone), .core_result(b_cres),
    .busy(b_busy), .done(b_done), .enc_pass(b_enc), .dec_pass(b_dec), .timeout(b_to),
    .pass_count(b_pc), .fail_count(b_fc));

  int b_rem = 0, b_starts = 0, b_bad = 0;
  logic b_cm = 1'b0, b_cc = 1'b0, b_chk = 1'b0;
  logic [127:0] b_cd = '0, b_seen_enc = '0, b_seen_dec = '0;
  logic [255:0] b_ck = '0, b_seen_key = '0;
  logic [384:0] b_snap = '0;

  always @(negedge clk) begin
    b_cdone_m = 1'b0;
    if (b_rem > 0) begin
      b_rem = b_rem - 1;
      if (b_rem == 0) begin
        b_cdone_m = 1'b1;
        b_cres = core_fn(b_cm, b_cd, b_ck) ^ {127'b0, b_cm & b_cc};
      end
    end
    if (rst) b_chk = 1'b0;
    else if (b_chk) begin
      if ({b_cmode, b_cdata, b_ckey} !== b_snap) b_bad++;
      if (b_cdone_m | b_spur) b_chk = 1'b0;
    end
    if (b_cstart) begin
      b_starts++;
      if (b_cmode) b_seen_dec = b_cdata;
      else begin b_seen_enc = b_cdata; b_seen_key = b_ckey; end
      b_cm = b_cmode; b_cd = b_cdata; b_ck = b_ckey; b_cc = corrupt;
      b_rem = b_cmode ? lat2 : lat1;
      b_chk = (b_rem > 0 && b_rem <= T);
      b_snap = {b_cmode, b_cdata, b_ckey};
    end
  end

  // ---------------- selected-instance views
  logic m_done, m_busy, m_enc, m_dec, m_to;
  int m_pc, m_fc, m_starts, m_bad;
  logic [127:0] m_seen_enc, m_seen_dec;
  logic [255:0] m_seen_key;
  assign m_done = sel ? b_done : a_done;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_enc  = sel ? b_enc  : a_enc;
  assign m_dec  = sel ? b_dec  : a_dec;
  assign m_to   = sel ? b_to   : a_to;
  assign m_pc   = sel ? int'(b_pc) : int'(a_pc);
  assign m_fc   = sel ? int'(b_fc) : int'(a_fc);
  assign m_starts   = sel ? b_starts : a_starts;
  assign m_bad      = sel ? b_bad : a_bad;
  assign m_seen_enc = sel ? b_seen_enc : a_seen_enc;
  assign m_seen_dec = sel ? b_seen_dec : a_seen_dec;
  assign m_seen_key = sel ? b_seen_key : a_seen_key;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_ctl"}, {a_cstart, a_cmode, a_busy, a_done, a_enc, a_dec, a_to, a_pc, a_fc}, 0);
    check({tag, "_a_data"}, {a_cdata, a_ckey}, 0);
    check({tag, "_b_ctl"}, {b_cstart, b_cmode, b_busy, b_done, b_enc, b_dec, b_to, b_pc, b_fc}, 0);
    check({tag, "_b_data"}, {b_cdata, b_ckey}, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete test on the selected instance, checked against the model.
  task automatic run_test(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                          input logic [255:0] key, input int l1, input int l2,
                          input logic corr, input logic mid);
    int s0, t0, lat, idx, lat_e, starts_e;
    logic seen, to_e, enc_e, dec_e;
    logic [127:0] ct;
    idx = sel ? 1 : 0;
    drv_pt = pt; drv_exp = exp; drv_key = key; lat1 = l1; lat2 = l2; corrupt = corr;
    @(negedge clk);
    s0 = m_starts; t0 = cyc; drv_start = 1'b1;
    @(negedge clk);
    drv_start = 1'b0;
    drv_pt = ~pt; drv_exp = ~exp; drv_key = ~key;
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (m_done) begin seen = 1'b1; lat = cyc - t0; end
      else begin drv_start = mid && (k == 4); @(negedge clk); end
    end
    drv_start = 1'b0;
    ct = core_fn(1'b0, pt, key);
    if (l1 == 0 || l1 > T) begin
      to_e = 1; enc_e = 0; dec_e = 0; lat_e = T + 3; starts_e = 1;
    end else if (l2 == 0 || l2 > T) begin
      to_e = 1; enc_e = 0; dec_e = 0; lat_e = 4 + l1 + T; starts_e = 2;
    end else begin
      to_e = 0; enc_e = (ct == exp);
      dec_e = ((core_fn(1'b1, ct, key) ^ {127'b0, corr}) == pt);
      lat_e = 4 + l1 + l2; starts_e = 2;
    end
    if (enc_e && dec_e && !to_e) begin if (e_pc[idx] < cap[idx]) e_pc[idx]++; end
    else if (e_fc[idx] < cap[idx]) e_fc[idx]++;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, lat, lat_e);
    check({tag, "_enc_pass"}, m_enc, enc_e);
    check({tag, "_dec_pass"}, m_dec, dec_e);
    check({tag, "_timeout"}, m_to, to_e);
    check({tag, "_pass_count"}, m_pc, e_pc[idx]);
    check({tag, "_fail_count"}, m_fc, e_fc[idx]);
    check({tag, "_core_starts"}, m_starts - s0, starts_e);
    check({tag, "_enc_data"}, m_seen_enc, pt);
    check({tag, "_core_key"}, m_seen_key, key);
    if (starts_e == 2) check({tag, "_dec_data"}, m_seen_dec, ct);
    check({tag, "_stable"}, m_bad, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, {m_done, m_busy}, 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, ex;
    logic [255:0] key;
    int s0, l1, l2;
    logic got_done;
    rst = 1'b1; sel = 1'b0; drv_start = 1'b0; a_spur = 1'b0; b_spur = 1'b0;
    corrupt = 1'b0; drv_pt = '0; drv_exp = '0; drv_key = '0; lat1 = 12; lat2 = 12;
    e_pc = '{0, 0}; e_fc = '{0, 0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // AES-128 vector, 12-cycle core
    sel = 1'b0;
    run_test("a_kat128", KPT, KCT128, K128, 12, 12, 1'b0, 1'b0);
    // five more passes: 2-bit pass tally saturates at 3
    for (int i = 0; i < 5; i++) begin
      pt = rnd128(); key = {128'b0, rnd128()};
      run_test("a_sat", pt, core_fn(1'b0, pt, key), key,
               int'($urandom_range(20, 1)), int'($urandom_range(20, 1)), 1'b0, 1'b0);
    end
    check("a_pc_saturated", a_pc, 3);
    pt = rnd128(); key = {128'b0, rnd128()};
    run_test("a_fail", pt, core_fn(1'b0, pt, key) ^ 128'h1, key, 3, 4, 1'b0, 1'b0);

    // AES-256 vector, then with expected ciphertext LSB flipped
    sel = 1'b1;
    run_test("b_kat256", KPT, KCT256, K256, 12, 12, 1'b0, 1'b0);
    run_test("b_kat256_flip", KPT, KCT256 ^ 128'h1, K256, 12, 12, 1'b0, 1'b0);
    // start pulsed during ENC_WAIT is ignored
    run_test("b_mid_start", KPT, KCT256, K256, 12, 9, 1'b0, 1'b1);
    // spurious core_done while idle
    s0 = b_starts;
    b_spur = 1'b1; @(negedge clk); b_spur = 1'b0; @(negedge clk);
    check("b_spur_idle", {b_busy, b_done}, 0);
    repeat (2) @(negedge clk);
    check("b_spur_starts", b_starts - s0, 0);
    check("b_spur_counts", {b_pc, b_fc}, {8'(e_pc[1]), 8'(e_fc[1])});
    // timeouts and the done-vs-timeout boundary
    run_test("b_enc_hang", KPT, KCT256, K256, 0, 12, 1'b0, 1'b0);
    run_test("b_enc_edge", KPT, KCT256, K256, T, 5, 1'b0, 1'b0);
    run_test("b_enc_late", KPT, KCT256, K256, T + 1, 5, 1'b0, 1'b0);
    run_test("b_dec_hang", KPT, KCT256, K256, 5, 0, 1'b0, 1'b0);
    run_test("b_dec_corrupt", KPT, KCT256, K256, 7, 6, 1'b1, 1'b0);
    // randomized vectors, latencies and faults
    for (int i = 0; i < 12; i++) begin
      pt = rnd128(); key = {rnd128(), rnd128()};
      ex = core_fn(1'b0, pt, key) ^ (($urandom_range(3, 0) == 0) ? rnd128() : 128'h0);
      l1 = int'($urandom_range(70, 1)); l2 = int'($urandom_range(70, 1));
      run_test("b_rand", pt, ex, key, l1, l2, 1'($urandom_range(3, 0) == 0), 1'b0);
    end

    // reset asserted while in DEC_WAIT
    drv_pt = KPT; drv_exp = KCT256; drv_key = K256; lat1 = 5; lat2 = 30; corrupt = 1'b0;
    s0 = b_starts;
    @(negedge clk); drv_start = 1'b1;
    @(negedge clk); drv_start = 1'b0;
    for (int k = 0; k < 100 && b_starts < s0 + 2; k++) @(negedge clk);
    check("b_rst_dec_started", b_starts - s0, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    got_done = 1'b0;
    repeat (4) begin @(negedge clk); got_done |= b_done; end
    rst = 1'b0;
    repeat (40) begin @(negedge clk); got_done |= b_done; end
    check("b_rst_no_done", {got_done, b_busy}, 0);
    e_pc = '{0, 0}; e_fc = '{0, 0};
    run_test("b_after_reset", KPT, KCT256, K256, 6, 8, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
